// File: rtl/nnl_fp32_pkg.sv
// FP32 field layout, NaN test and collector FSM states shared by the
// Layer7 argmax collector and its comparator.
package nnl_fp32_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;
    localparam logic [EXP_MSB-EXP_LSB:0] EXP_ALL1 = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[EXP_MSB:EXP_LSB] == EXP_ALL1) && (x[MANT_W-1:0] != '0);
    endfunction

endpackage

// File: rtl/layer7_argmax_collector_if.sv
// Stream, result and histogram-read signals between Layer7 (master side)
// and the argmax collector (slave side).
interface layer7_argmax_collector_if #(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNELS   = 7,
    parameter int IDX_W      = 3
);
    logic                           Valid_In;
    logic [DATA_WIDHT*CHANNELS-1:0] Data_In;
    logic                           Valid_Out;
    logic [IDX_W-1:0]               Class_Out;
    logic [DATA_WIDHT-1:0]          Max_Out;
    logic                           Busy;
    logic                           Overflow;
    logic [IDX_W-1:0]               Hist_Sel;
    logic [15:0]                    Hist_Count;

    modport master (
        output Valid_In, Data_In, Hist_Sel,
        input  Valid_Out, Class_Out, Max_Out, Busy, Overflow, Hist_Count
    );

    modport slave (
        input  Valid_In, Data_In, Hist_Sel,
        output Valid_Out, Class_Out, Max_Out, Busy, Overflow, Hist_Count
    );
endinterface

// File: rtl/fp32_gt_compare.sv
// Combinational a > b for FP32 in sign-magnitude order: -0 equals +0,
// a NaN never beats a non-NaN, denormals ordered by their raw bits.
module fp32_gt_compare
    import nnl_fp32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        a_gt_b
);
    logic a_nan;
    logic b_nan;
    logic a_zero;
    logic b_zero;

    assign a_nan  = is_nan(a);
    assign b_nan  = is_nan(b);
    assign a_zero = (a[EXP_MSB:0] == '0);
    assign b_zero = (b[EXP_MSB:0] == '0);

    always_comb begin
        a_gt_b = 1'b0;
        if (a_nan) begin
            a_gt_b = 1'b0;
        end else if (b_nan) begin
            a_gt_b = 1'b1;
        end else if (a_zero && b_zero) begin
            a_gt_b = 1'b0;
        end else if (a[SIGN_BIT] != b[SIGN_BIT]) begin
            a_gt_b = !a[SIGN_BIT];
        end else if (!a[SIGN_BIT]) begin
            a_gt_b = (a[EXP_MSB:0] > b[EXP_MSB:0]);
        end else begin
            // both negative: smaller magnitude is the larger value
            a_gt_b = (a[EXP_MSB:0] < b[EXP_MSB:0]);
        end
    end
endmodule

// File: rtl/layer7_argmax_collector.sv
// Serial argmax over each Layer7 score vector with a one-deep pending buffer.
// Optional per-class hit histogram when CLASS_HIST_EN is defined.
module layer7_argmax_collector
    import nnl_fp32_pkg::*;
#(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNELS   = 7,
    parameter int IDX_W      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    layer7_argmax_collector_if.slave  bus
);
    localparam int                 SLOTS  = 2 ** IDX_W;
    localparam logic [IDX_W-1:0]   LAST_I = IDX_W'((CHANNELS > 1) ? CHANNELS - 1 : 1);

    state_t                           state_reg;
    logic [DATA_WIDHT*CHANNELS-1:0]   vec_reg;
    logic [DATA_WIDHT*CHANNELS-1:0]   pend_vec_reg;
    logic                             pend_valid_reg;
    logic [DATA_WIDHT-1:0]            best_reg;
    logic [IDX_W-1:0]                 idx_reg;
    logic [IDX_W-1:0]                 i_reg;
    logic                             valid_out_reg;
    logic [IDX_W-1:0]                 class_reg;
    logic [DATA_WIDHT-1:0]            max_reg;
    logic                             overflow_reg;

    logic [DATA_WIDHT-1:0]            elem [SLOTS];
    logic [DATA_WIDHT-1:0]            cur_elem;
    logic                             take;
    logic [DATA_WIDHT-1:0]            best_next;
    logic [IDX_W-1:0]                 idx_next;
    logic                             done;

    // Unused index slots alias element 0 so they can never win.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_elem
            if (gi < CHANNELS) begin : g_real
                assign elem[gi] = vec_reg[gi*DATA_WIDHT +: DATA_WIDHT];
            end else begin : g_pad
                assign elem[gi] = vec_reg[DATA_WIDHT-1:0];
            end
        end
    endgenerate

    assign cur_elem = elem[i_reg];

    fp32_gt_compare u_cmp (
        .a      (cur_elem),
        .b      (best_reg),
        .a_gt_b (take)
    );

    assign best_next = take ? cur_elem : best_reg;
    assign idx_next  = take ? i_reg : idx_reg;
    assign done      = (state_reg == ST_SCAN) && (i_reg == LAST_I);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            vec_reg        <= '0;
            pend_vec_reg   <= '0;
            pend_valid_reg <= 1'b0;
            best_reg       <= '0;
            idx_reg        <= '0;
            i_reg          <= '0;
            valid_out_reg  <= 1'b0;
            class_reg      <= '0;
            max_reg        <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            valid_out_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.Valid_In) begin
                        vec_reg   <= bus.Data_In;
                        best_reg  <= bus.Data_In[DATA_WIDHT-1:0];
                        idx_reg   <= '0;
                        i_reg     <= IDX_W'(1);
                        state_reg <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (done) begin
                        class_reg     <= idx_next;
                        max_reg       <= best_next;
                        valid_out_reg <= 1'b1;
                        idx_reg       <= '0;
                        i_reg         <= IDX_W'(1);
                        // Chain straight into the next vector with no idle cycle.
                        if (pend_valid_reg) begin
                            vec_reg        <= pend_vec_reg;
                            best_reg       <= pend_vec_reg[DATA_WIDHT-1:0];
                            pend_valid_reg <= bus.Valid_In;
                            if (bus.Valid_In) begin
                                pend_vec_reg <= bus.Data_In;
                            end
                        end else if (bus.Valid_In) begin
                            vec_reg  <= bus.Data_In;
                            best_reg <= bus.Data_In[DATA_WIDHT-1:0];
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        best_reg <= best_next;
                        idx_reg  <= idx_next;
                        i_reg    <= i_reg + 1'b1;
                        if (bus.Valid_In) begin
                            if (!pend_valid_reg) begin
                                pend_vec_reg   <= bus.Data_In;
                                pend_valid_reg <= 1'b1;
                            end else begin
                                overflow_reg <= 1'b1;
                            end
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.Valid_Out = valid_out_reg;
    assign bus.Class_Out = class_reg;
    assign bus.Max_Out   = max_reg;
    assign bus.Overflow  = overflow_reg;
    assign bus.Busy      = (state_reg == ST_SCAN) || pend_valid_reg;

`ifdef CLASS_HIST_EN
    logic [15:0] hist_cnt [SLOTS];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_hist
            if (gi < CHANNELS) begin : g_cnt
                logic [15:0] cnt_reg;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        cnt_reg <= '0;
                    end else if (done && (idx_next == IDX_W'(gi)) && (cnt_reg != 16'hFFFF)) begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                assign hist_cnt[gi] = cnt_reg;
            end else begin : g_none
                assign hist_cnt[gi] = '0;
            end
        end
    endgenerate

    assign bus.Hist_Count = hist_cnt[bus.Hist_Sel];
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^bus.Hist_Sel;
    assign bus.Hist_Count  = '0;
`endif

endmodule

// File: tb/tb_layer7_argmax_collector.sv
// Directed bench for layer7_argmax_collector; histogram expectations follow CLASS_HIST_EN.
module tb_layer7_argmax_collector;
    localparam int DW = 32;
    localparam int CH = 7;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    layer7_argmax_collector_if #(.DATA_WIDHT(DW), .CHANNELS(CH), .IDX_W(IW)) bus ();

    layer7_argmax_collector #(.DATA_WIDHT(DW), .CHANNELS(CH), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW*CH-1:0] pk(input logic [31:0] e0, e1, e2, e3, e4, e5, e6);
        return {e6, e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one vector for a single cycle; returns just after its capture edge.
    task automatic send(input logic [DW*CH-1:0] v);
        bus.Valid_In = 1'b1;
        bus.Data_In  = v;
        step();
        bus.Valid_In = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int lat);
        bit seen;
        seen = 0;
        lat  = -1;
        for (int k = 1; k <= limit && !seen; k++) begin
            step();
            if (bus.Valid_Out) begin
                lat  = k;
                seen = 1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic run_vec(input string name, input logic [DW*CH-1:0] v,
                           input logic [IW-1:0] exp_cls, input logic [31:0] exp_max);
        int lat;
        send(v);
        wait_valid(20, lat);
        vectors++;
        if (lat !== 6) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected 6", name, lat);
        end
        vectors++;
        if (bus.Class_Out !== exp_cls || bus.Max_Out !== exp_max) begin
            miscompares++;
            $display("FAIL %s result: got class %0d max %h expected class %0d max %h",
                     name, bus.Class_Out, bus.Max_Out, exp_cls, exp_max);
        end else begin
            $display("vec %s: class %0d max %h latency %0d", name, bus.Class_Out, bus.Max_Out, lat);
        end
    endtask

    task automatic test_reset();
        bus.Valid_In = 1'b0;
        bus.Data_In  = '0;
        bus.Hist_Sel = '0;
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({bus.Valid_Out, bus.Class_Out, bus.Max_Out, bus.Busy, bus.Overflow, bus.Hist_Count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got vo=%b cls=%0d max=%h busy=%b ovf=%b hist=%0d expected all 0",
                     bus.Valid_Out, bus.Class_Out, bus.Max_Out, bus.Busy, bus.Overflow, bus.Hist_Count);
        end else begin
            $display("reset: all outputs 0");
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        run_vec("single", pk(32'h3F800000, 32'h40000000, 32'h3F000000, 32'hC0400000,
                             32'h40F00000, 32'h40E00000, 32'h00000000), 3'd4, 32'h40F00000);
        step();
        vectors++;
        if (bus.Valid_Out !== 1'b0 || bus.Class_Out !== 3'd4 || bus.Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_hold: got vo=%b cls=%0d busy=%b expected vo=0 cls=4 busy=0",
                     bus.Valid_Out, bus.Class_Out, bus.Busy);
        end
    endtask

    task automatic test_ties();
        run_vec("tie_equal", pk(32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000,
                                32'h40400000, 32'h40400000, 32'h40400000), 3'd0, 32'h40400000);
        run_vec("tie_zero", pk(32'h80000000, 32'h00000000, 32'hBF800000, 32'hBF800000,
                               32'hBF800000, 32'hBF800000, 32'hBF800000), 3'd0, 32'h80000000);
    endtask

    task automatic test_nan();
        run_vec("nan_mix", pk(32'h7FC00000, 32'hFF800000, 32'hBF800000, 32'hFF800000,
                              32'hFF800000, 32'hFF800000, 32'hFF800000), 3'd2, 32'hBF800000);
        run_vec("all_nan", pk(32'h7FC00001, 32'h7F800001, 32'hFFC00000, 32'h7FFFFFFF,
                              32'hFF800001, 32'h7FC00000, 32'hFFFFFFFF), 3'd0, 32'h7FC00001);
        run_vec("denorm", pk(32'h00000001, 32'h00000002, 32'h807FFFFF, 32'hFF800000,
                             32'h00000000, 32'h80000001, 32'h00000001), 3'd1, 32'h00000002);
    endtask

    task automatic test_back_to_back();
        int n_pulse;
        int pulse_cyc [2];
        logic [IW-1:0] pulse_cls [2];
        n_pulse = 0;
        bus.Valid_In = 1'b1;
        bus.Data_In  = pk(0, 32'h3F800000, 0, 0, 0, 0, 0);
        step();
        bus.Data_In  = pk(0, 0, 0, 0, 0, 32'h40000000, 0);
        step();
        bus.Data_In  = pk(0, 0, 0, 32'h40400000, 0, 0, 0);
        step();
        bus.Valid_In = 1'b0;
        vectors++;
        if (bus.Overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_overflow_set: got %b expected 1", bus.Overflow);
        end
        for (int c = 3; c <= 30; c++) begin
            step();
            if (bus.Valid_Out) begin
                if (n_pulse < 2) begin
                    pulse_cyc[n_pulse] = c;
                    pulse_cls[n_pulse] = bus.Class_Out;
                end
                n_pulse++;
            end
            if (c == 11) begin
                vectors++;
                if (bus.Busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_busy_mid: got %b expected 1", bus.Busy);
                end
            end
            if (c == 12) begin
                vectors++;
                if (bus.Busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_busy_end: got %b expected 0", bus.Busy);
                end
            end
        end
        vectors++;
        if (n_pulse !== 2) begin
            miscompares++;
            $display("FAIL b2b_pulses: got %0d expected 2", n_pulse);
        end else begin
            vectors++;
            if (pulse_cyc[0] !== 6 || pulse_cyc[1] !== 12 || pulse_cls[0] !== 3'd1 || pulse_cls[1] !== 3'd5) begin
                miscompares++;
                $display("FAIL b2b_results: got cyc %0d/%0d cls %0d/%0d expected cyc 6/12 cls 1/5",
                         pulse_cyc[0], pulse_cyc[1], pulse_cls[0], pulse_cls[1]);
            end else begin
                $display("b2b: results at 6 and 12, classes 1 and 5, third dropped");
            end
        end
        vectors++;
        if (bus.Overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_overflow_sticky: got %b expected 1", bus.Overflow);
        end
    endtask

    task automatic test_reset_mid_scan();
        int n_pulse;
        n_pulse = 0;
        bus.Valid_In = 1'b1;
        bus.Data_In  = pk(0, 0, 0, 0, 32'h3F800000, 0, 0);
        step();
        bus.Valid_In = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.Valid_Out, bus.Class_Out, bus.Max_Out, bus.Busy, bus.Overflow} !== '0) begin
            miscompares++;
            $display("FAIL midscan_reset_outputs: got cls=%0d max=%h busy=%b ovf=%b expected all 0",
                     bus.Class_Out, bus.Max_Out, bus.Busy, bus.Overflow);
        end
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.Valid_Out) n_pulse++;
        end
        vectors++;
        if (n_pulse !== 0) begin
            miscompares++;
            $display("FAIL midscan_no_valid: got %0d pulses expected 0", n_pulse);
        end else begin
            $display("midscan reset: scan aborted, no result");
        end
        run_vec("after_rst", pk(0, 0, 0, 0, 0, 0, 32'h3F800000), 3'd6, 32'h3F800000);
    endtask

    task automatic test_hist();
        logic [15:0] exp6;
        logic [15:0] exp1;
`ifdef CLASS_HIST_EN
        exp6 = 16'd5;
        exp1 = 16'd2;
`else
        exp6 = 16'd0;
        exp1 = 16'd0;
`endif
        do_reset();
        for (int n = 0; n < 5; n++)
            run_vec("hist6", pk(0, 0, 0, 0, 0, 0, 32'h3F800000 + 32'(n)), 3'd6, 32'h3F800000 + 32'(n));
        for (int n = 0; n < 2; n++)
            run_vec("hist1", pk(0, 32'h40000000, 0, 0, 0, 0, 0), 3'd1, 32'h40000000);
        bus.Hist_Sel = 3'd6;
        #1;
        vectors++;
        if (bus.Hist_Count !== exp6) begin
            miscompares++;
            $display("FAIL hist_sel6: got %0d expected %0d", bus.Hist_Count, exp6);
        end
        bus.Hist_Sel = 3'd1;
        #1;
        vectors++;
        if (bus.Hist_Count !== exp1) begin
            miscompares++;
            $display("FAIL hist_sel1: got %0d expected %0d", bus.Hist_Count, exp1);
        end
        bus.Hist_Sel = 3'd7;
        #1;
        vectors++;
        if (bus.Hist_Count !== 16'd0) begin
            miscompares++;
            $display("FAIL hist_sel7: got %0d expected 0", bus.Hist_Count);
        end
        bus.Hist_Sel = 3'd0;
        #1;
        vectors++;
        if (bus.Hist_Count !== 16'd0) begin
            miscompares++;
            $display("FAIL hist_sel0: got %0d expected 0", bus.Hist_Count);
        end
        $display("hist: expected sel6=%0d sel1=%0d", exp6, exp1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_ties();
        test_nan();
        test_back_to_back();
        test_reset_mid_scan();
        test_hist();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
